// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared types and helpers for the 16x16 matrix scanner
package matrix_pkg;

    localparam int GRID = 16;

    typedef logic [GRID-1:0][GRID-1:0] frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SNAP,
        BLANK,
        DRIVE
    } scan_state_t;

    // Gather one row of a plane into column order: bit x = plane[x][row].
    function automatic logic [GRID-1:0] column_slice(input frame_t plane, input logic [3:0] row);
        logic [GRID-1:0] cols;
        cols = '0;
        for (int x = 0; x < GRID; x++) begin
            cols[x] = plane[x][row];
        end
        return cols;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - loadable saturating down-counter with done flag
module scan_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             done
);

    // Reload on request, otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/matrix_scan.sv
// rtl/matrix_scan.sv - row-multiplexed scanner for a 16x16 bicolour LED matrix
module matrix_scan
    import matrix_pkg::*;
#(
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [GRID-1:0][GRID-1:0]  green_in,
    input  logic [GRID-1:0][GRID-1:0]  red_in,
    output logic [GRID-1:0]            row_sel,
    output logic [GRID-1:0]            col_green,
    output logic [GRID-1:0]            col_red,
    output logic                       frame_start,
    output logic [3:0]                 row_idx
);

    localparam int MAX_CYCLES = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    scan_state_t   state;
    scan_state_t   next_state;
    logic [3:0]    row_next;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic [CW-1:0] tmr_count;
    logic          tmr_done;
    frame_t        snap_green;
    frame_t        snap_red;

    scan_timer #(.WIDTH(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .done     (tmr_done)
    );

    // State and row register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SNAP;
            row_idx <= 4'd0;
        end else begin
            state   <= next_state;
            row_idx <= row_next;
        end
    end

    // Next-state logic; the timer is reloaded on every state entry.
    always_comb begin
        next_state   = state;
        row_next     = row_idx;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        if (!en) begin
            next_state = IDLE;
            row_next   = 4'd0;
            tmr_load   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    next_state = SNAP;
                    row_next   = 4'd0;
                    tmr_load   = 1'b1;
                end
                SNAP: begin
                    next_state   = BLANK;
                    row_next     = 4'd0;
                    tmr_load     = 1'b1;
                    tmr_load_val = BLANK_LOAD;
                end
                BLANK: begin
                    if (tmr_done) begin
                        next_state   = DRIVE;
                        tmr_load     = 1'b1;
                        tmr_load_val = DWELL_LOAD;
                    end
                end
                DRIVE: begin
                    if (tmr_done) begin
                        tmr_load = 1'b1;
                        if (row_idx == 4'd15) begin
                            next_state = SNAP;
                        end else begin
                            next_state   = BLANK;
                            row_next     = row_idx + 4'd1;
                            tmr_load_val = BLANK_LOAD;
                        end
                    end
                end
                default: begin
                    next_state = IDLE;
                    tmr_load   = 1'b1;
                end
            endcase
        end
    end

    // Frame snapshot, taken only in SNAP so mid-frame plane updates never tear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_green <= '0;
            snap_red   <= '0;
        end else if (en && state == SNAP) begin
            snap_green <= green_in;
            snap_red   <= red_in;
        end
    end

    // Registered pin outputs; columns change only on the first blank cycle, never while lit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_sel     <= '0;
            col_green   <= '0;
            col_red     <= '0;
            frame_start <= 1'b0;
        end else if (!en) begin
            row_sel     <= '0;
            col_green   <= '0;
            col_red     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (state == SNAP);
            row_sel     <= (state == DRIVE) ? (GRID'(1) << row_idx) : '0;
            if (state == IDLE) begin
                col_green <= '0;
                col_red   <= '0;
            end else if (state == BLANK && tmr_count == BLANK_LOAD) begin
                col_green <= column_slice(snap_green, row_idx);
                col_red   <= column_slice(snap_red, row_idx);
            end
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// tb/tb_matrix_scan.sv - randomized self-checking bench for matrix_scan
module tb_matrix_scan;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int ROWP  = DW + BL;
    localparam int FRAME = 16 * ROWP + 1;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [15:0][15:0]    green_in;
    logic [15:0][15:0]    red_in;
    logic [15:0]          row_sel;
    logic [15:0]          col_green;
    logic [15:0]          col_red;
    logic                 frame_start;
    logic [3:0]           row_idx;

    always #5 clk = ~clk;

    matrix_scan #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BL)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .green_in    (green_in),
        .red_in      (red_in),
        .row_sel     (row_sel),
        .col_green   (col_green),
        .col_red     (col_red),
        .frame_start (frame_start),
        .row_idx     (row_idx)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the frame, counted from the frame_start cycle.
    int                pending;
    int                k;
    logic [15:0][15:0] ref_g;
    logic [15:0][15:0] ref_r;
    logic [15:0]       exp_rs;
    logic [15:0]       exp_cg;
    logic [15:0]       exp_cr;
    logic              exp_fs;
    logic [15:0]       prev_rs;
    logic [15:0]       prev_cg;
    logic [15:0]       prev_cr;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] row_of(input logic [15:0][15:0] f, input int row);
        logic [15:0] s;
        for (int x = 0; x < 16; x++) s[x] = f[x][row];
        return s;
    endfunction

    function automatic logic in_drive_of(input int row);
        return (pending == 0) && (k >= 1) && ((k - 1) / ROWP == row) && ((k - 1) % ROWP >= BL);
    endfunction

    task automatic model_reset();
        pending = 1;
        k       = 0;
        ref_g   = '0;
        ref_r   = '0;
        exp_rs  = '0;
        exp_cg  = '0;
        exp_cr  = '0;
        exp_fs  = 1'b0;
        prev_rs = '0;
        prev_cg = '0;
        prev_cr = '0;
    endtask

    task automatic step();
        logic              e;
        logic [15:0][15:0] g;
        logic [15:0][15:0] r;
        int                row;
        int                w;
        @(posedge clk);
        e = en;
        g = green_in;
        r = red_in;
        exp_fs = 1'b0;
        exp_rs = '0;
        if (!e) begin
            pending = 2;
            exp_cg  = '0;
            exp_cr  = '0;
        end else if (pending > 0) begin
            pending--;
            if (pending == 0) begin
                k      = 0;
                ref_g  = g;
                ref_r  = r;
                exp_fs = 1'b1;
            end else begin
                exp_cg = '0;
                exp_cr = '0;
            end
        end else begin
            k++;
            if (k == FRAME) begin
                k      = 0;
                ref_g  = g;
                ref_r  = r;
                exp_fs = 1'b1;
            end else begin
                row    = (k - 1) / ROWP;
                w      = (k - 1) % ROWP;
                exp_cg = row_of(ref_g, row);
                exp_cr = row_of(ref_r, row);
                if (w >= BL) exp_rs = 16'(1) << row;
            end
        end
        #1;
        check("row_sel", row_sel, exp_rs);
        check("col_green", col_green, exp_cg);
        check("col_red", col_red, exp_cr);
        check("frame_start", frame_start, exp_fs);
        check("row_sel_onehot0", $onehot0(row_sel), 1);
        if (prev_rs != '0 && row_sel != '0) begin
            check("col_green_stable_lit", col_green, prev_cg);
            check("col_red_stable_lit", col_red, prev_cr);
        end
        prev_rs = row_sel;
        prev_cg = col_green;
        prev_cr = col_red;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_planes();
        for (int x = 0; x < 16; x++) begin
            green_in[x] = 16'($urandom);
            red_in[x]   = 16'($urandom);
        end
    endtask

    initial begin
        int guard;
        rst      = 1'b0;
        en       = 1'b0;
        green_in = '0;
        red_in   = '0;
        model_reset();
        #12;
        check("reset_row_sel", row_sel, 16'h0);
        check("reset_col_green", col_green, 16'h0);
        check("reset_col_red", col_red, 16'h0);
        check("reset_frame_start", frame_start, 1'b0);
        check("reset_row_idx", row_idx, 4'd0);

        // Single green pixel at column 3, row 0; planes go all-ones mid-frame.
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b1;
        green_in[3][0] = 1'b1;
        run(1);
        check("first_frame_start", frame_start, 1'b1);
        run(3);
        check("row0_lit_cycle4", row_sel, 16'h0001);
        check("row0_col_green", col_green, 16'h0008);
        run(15);
        green_in = '1;
        run(FRAME + 40);
        check("all_ones_after_resnap", col_green, 16'hFFFF);

        // Amber pixel: both planes set at column 5, row 7.
        green_in = '0;
        red_in   = '0;
        green_in[5][7] = 1'b1;
        red_in[5][7]   = 1'b1;
        run(FRAME + 10);
        guard = 0;
        while (!in_drive_of(7) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("wait_row7_timeout", guard < 2 * FRAME, 1);
        check("amber_row_sel", row_sel, 16'h0080);
        check("amber_green", col_green, 16'h0020);
        check("amber_red", col_red, 16'h0020);

        // Drop enable while row 9 is lit, then resume.
        rand_planes();
        guard = 0;
        while (!in_drive_of(9) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("wait_row9_timeout", guard < 2 * FRAME, 1);
        en = 1'b0;
        step();
        check("en_off_row_sel", row_sel, 16'h0);
        check("en_off_cols", {col_green, col_red}, 32'h0);
        run(3);
        en = 1'b1;
        run(2);
        check("resume_frame_start", frame_start, 1'b1);
        run(BL + 1);
        check("resume_row0_first", row_sel, 16'h0001);

        // Random planes over several frames with occasional enable drops.
        for (int i = 0; i < 3 * FRAME + 50; i++) begin
            if ($urandom_range(0, 7) == 0) rand_planes();
            if (i > FRAME) en = ($urandom_range(0, 60) != 0);
            step();
        end
        en = 1'b1;

        // Asynchronous reset while a row is lit.
        guard = 0;
        while (row_sel == '0 && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("wait_lit_timeout", guard < 2 * FRAME, 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_row_sel", row_sel, 16'h0);
        check("async_reset_row_idx", row_idx, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run(1);
        check("post_reset_frame_start", frame_start, 1'b1);
        run(FRAME + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
